// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8 request/grant bundle.
// Requesters drive req; the arbiter returns a one-hot grant and its index.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and index.
// Optional MAX_HOLD forces rotation away from an owner when others wait.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 0
) (
    input  logic          CLK,
    input  logic          ASYNCRESETN,
    rr_arbiter8_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // Hold limit is only meaningful when MAX_HOLD is non-zero.
    localparam bit LIMITED = (MAX_HOLD > 0);
    localparam logic [7:0] HOLD_LAST =
        LIMITED ? 8'(MAX_HOLD - 1) : 8'hFF;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;

    logic [7:0] req;
    logic [7:0] others;
    logic [7:0] cand;
    logic       own_req;
    logic       at_limit;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [7:0] pick_onehot;

    // Scan r upward from p+1 (mod 8); p itself is checked last.
    function automatic logic [3:0] rr_pick(
        input logic [7:0] r,
        input logic [2:0] p
    );
        logic [3:0] res;
        logic [2:0] i;
        res = 4'd0;
        for (int k = 8; k >= 1; k--) begin
            i = p + 3'(k);
            if (r[i]) begin
                res = {1'b1, i};
            end
        end
        return res;
    endfunction

    assign req     = bus.req;
    assign own_req = req[ptr_q];
    assign others  = req & ~(8'd1 << ptr_q);

    // While busy the owner is never a candidate: either it released,
    // or it is being rotated away by the hold limit.
    assign cand     = (state_q == ST_BUSY) ? others : req;
    assign at_limit = LIMITED && (hold_cnt_q == HOLD_LAST);

    // Winner selection from the candidate set.
    always_comb begin
        logic [3:0] pick;
        pick        = rr_pick(cand, ptr_q);
        pick_found  = pick[3];
        pick_idx    = pick[2:0];
        pick_onehot = 8'd1 << pick[2:0];
    end

    // Next-state decision for owner, pointer, hold count and outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        valid_d    = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_BUSY;
                    ptr_d      = pick_idx;
                    hold_cnt_d = 8'd0;
                    grant_d    = pick_onehot;
                    idx_d      = pick_idx;
                    valid_d    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!own_req) begin
                    hold_cnt_d = 8'd0;
                    if (pick_found) begin
                        ptr_d   = pick_idx;
                        grant_d = pick_onehot;
                        idx_d   = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 8'd0;
                        idx_d   = 3'd0;
                        valid_d = 1'b0;
                    end
                end else if (at_limit && pick_found) begin
                    ptr_d      = pick_idx;
                    hold_cnt_d = 8'd0;
                    grant_d    = pick_onehot;
                    idx_d      = pick_idx;
                end else if (!at_limit && hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = 8'd0;
                grant_d    = 8'd0;
                idx_d      = 3'd0;
                valid_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; ptr resets to 7 so requester 0 leads.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd7;
            hold_cnt_q <= 8'd0;
            grant_q    <= 8'd0;
            idx_q      <= 3'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random checks for rr_arbiter8.
// Two instances: unlimited hold and MAX_HOLD=4, sharing req and reset.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_v;
    int         total;
    int         bad;

    rr_arbiter8_if if0 ();
    rr_arbiter8_if if4 ();

    assign if0.req = req_v;
    assign if4.req = req_v;

    rr_arbiter8 dut0 (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .bus         (if0.slave)
    );

    rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .bus         (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] enc8(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req_v = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        req_v = 8'h00;
        rst_n = 1'b0;
        #1;
        exp = 12'h000;
        total++;
        if ({if4.grant, if4.grant_idx, if4.grant_valid} !== exp) begin
            bad++;
            $display("FAIL reset_out got=%h want=%h",
                     {if4.grant, if4.grant_idx, if4.grant_valid}, exp);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({if4.grant, if4.grant_idx, if4.grant_valid} !== exp) begin
                bad++;
                $display("FAIL idle_c%0d got=%h want=%h", c,
                         {if4.grant, if4.grant_idx, if4.grant_valid}, exp);
            end
        end
    endtask

    task automatic test_rotation();
        logic [2:0] prev;
        logic [2:0] e;
        apply_reset();
        req_v = 8'hFF;
        tick();
        total++;
        if ({if0.grant, if0.grant_idx, if0.grant_valid} !== {8'h01, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL rot_first got=%h/%0d want=01/0",
                     if0.grant, if0.grant_idx);
        end
        prev = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            req_v = ~(8'd1 << prev);
            tick();
            e = 3'(k);
            total++;
            if ({if0.grant, if0.grant_idx, if0.grant_valid} !==
                {8'd1 << e, e, 1'b1}) begin
                bad++;
                $display("FAIL rot0_k%0d got=%h/%0d want=%h/%0d", k,
                         if0.grant, if0.grant_idx, 8'd1 << e, e);
            end
            total++;
            if ({if4.grant, if4.grant_idx, if4.grant_valid} !==
                {8'd1 << e, e, 1'b1}) begin
                bad++;
                $display("FAIL rot4_k%0d got=%h/%0d want=%h/%0d", k,
                         if4.grant, if4.grant_idx, 8'd1 << e, e);
            end
            prev = e;
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        req_v = 8'h20;
        tick();
        req_v = 8'h21;
        tick();
        total++;
        if (if0.grant !== 8'h20) begin
            bad++;
            $display("FAIL wrap_keep5 got=%h want=20", if0.grant);
        end
        req_v = 8'h01;
        tick();
        total++;
        if ({if0.grant, if0.grant_idx} !== {8'h01, 3'd0}) begin
            bad++;
            $display("FAIL wrap_5to0 got=%h/%0d want=01/0",
                     if0.grant, if0.grant_idx);
        end
        apply_reset();
        req_v = 8'h40;
        tick();
        req_v = 8'h03;
        tick();
        total++;
        if ({if0.grant, if0.grant_idx} !== {8'h01, 3'd0}) begin
            bad++;
            $display("FAIL wrap_6to0 got=%h/%0d want=01/0",
                     if0.grant, if0.grant_idx);
        end
    endtask

    task automatic test_hold_limit();
        logic [7:0] e4;
        apply_reset();
        req_v = 8'h44;
        for (int c = 0; c < 12; c++) begin
            tick();
            e4 = (c >= 4 && c < 8) ? 8'h40 : 8'h04;
            total++;
            if ({if4.grant, if4.grant_idx} !== {e4, enc8(e4)}) begin
                bad++;
                $display("FAIL hold4_c%0d got=%h/%0d want=%h", c,
                         if4.grant, if4.grant_idx, e4);
            end
            total++;
            if (if0.grant !== 8'h04) begin
                bad++;
                $display("FAIL hold0_c%0d got=%h want=04", c, if0.grant);
            end
        end
        apply_reset();
        req_v = 8'h04;
        repeat (10) tick();
        total++;
        if (if4.grant !== 8'h04) begin
            bad++;
            $display("FAIL solo_keep got=%h want=04", if4.grant);
        end
        total++;
        if (dut4.hold_cnt_q !== 8'd3) begin
            bad++;
            $display("FAIL solo_sat got=%0d want=3", dut4.hold_cnt_q);
        end
        req_v = 8'h44;
        tick();
        total++;
        if ({if4.grant, if4.grant_idx} !== {8'h40, 3'd6}) begin
            bad++;
            $display("FAIL late_rot got=%h/%0d want=40/6",
                     if4.grant, if4.grant_idx);
        end
    endtask

    task automatic test_toggle();
        logic [7:0] e;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            req_v = (c % 2 == 0) ? 8'h08 : 8'h00;
            e = req_v;
            tick();
            total++;
            if ({if4.grant, if4.grant_idx, if4.grant_valid} !==
                {e, enc8(e), |e}) begin
                bad++;
                $display("FAIL toggle_c%0d got=%h/%0d/%b want=%h", c,
                         if4.grant, if4.grant_idx, if4.grant_valid, e);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req_v = 8'hFF;
        tick();
        total++;
        if (if4.grant !== 8'h01) begin
            bad++;
            $display("FAIL pre_arst got=%h want=01", if4.grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if4.grant, if4.grant_idx, if4.grant_valid,
             if0.grant, if0.grant_idx, if0.grant_valid} !== 24'h0) begin
            bad++;
            $display("FAIL arst_now got=%h/%h want=0/0",
                     if4.grant, if0.grant);
        end
        tick();
        rst_n = 1'b1;
        total++;
        if (if4.grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_hold got=%b want=0", if4.grant_valid);
        end
        tick();
        total++;
        if ({if4.grant, if4.grant_idx} !== {8'h01, 3'd0}) begin
            bad++;
            $display("FAIL post_arst got=%h/%0d want=01/0",
                     if4.grant, if4.grant_idx);
        end
    endtask

    task automatic test_random();
        logic [7:0] rq;
        logic [7:0] g4;
        logic [7:0] g0;
        int         wt[8];
        apply_reset();
        for (int i = 0; i < 8; i++) wt[i] = 0;
        rq = 8'h00;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            req_v = rq;
            tick();
            g4 = if4.grant;
            g0 = if0.grant;
            total++;
            if (!(g4 == 8'h00 || $onehot(g4)) || !(g0 == 8'h00 || $onehot(g0))) begin
                bad++;
                $display("FAIL rnd_onehot cyc=%0d got=%h/%h", cyc, g4, g0);
            end
            total++;
            if ({if4.grant_idx, if4.grant_valid, if0.grant_idx, if0.grant_valid} !==
                {enc8(g4), |g4, enc8(g0), |g0}) begin
                bad++;
                $display("FAIL rnd_enc cyc=%0d got=%0d/%0d want=%0d/%0d", cyc,
                         if4.grant_idx, if0.grant_idx, enc8(g4), enc8(g0));
            end
            total++;
            if (((g4 | g0) & ~rq) !== 8'h00) begin
                bad++;
                $display("FAIL rnd_noreq cyc=%0d got=%h/%h req=%h", cyc, g4, g0, rq);
            end
            for (int i = 0; i < 8; i++) begin
                if (rq[i] && !g4[i]) wt[i]++;
                else wt[i] = 0;
                total++;
                if (wt[i] > 28) begin
                    bad++;
                    $display("FAIL rnd_wait cyc=%0d req=%0d got=%0d want<=28",
                             cyc, i, wt[i]);
                    wt[i] = 0;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (rq[i]) begin
                    if ((g4[i] || g0[i]) && ($urandom % 4 == 0)) rq[i] = 1'b0;
                end else if ($urandom % 8 == 0) begin
                    rq[i] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_v = 8'h00;
        test_reset();
        test_rotation();
        test_wrap();
        test_hold_limit();
        test_toggle();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
